// File: rtl/online_to_binary.sv
// Online (MSD-first signed-digit) to two's-complement converter using Q/QM on-the-fly conversion.
// Optional macro OTB_DIGIT_CHECK_EN adds a sticky o_digit_error flag for the out-of-set digit -r.
//
// state     | meaning
// S_IDLE    | waiting for i_start; digits ignored
// S_CONVERT | accepting digits, Q/QM updated per valid digit
// S_DONE    | o_result just loaded, o_result_valid high for this cycle
module online_to_binary #(
  parameter  int RADIX_LOG  = 2,
  parameter  int NUM_DIGITS = 4,
  localparam int radix_bits = RADIX_LOG + 1,
  localparam int W          = NUM_DIGITS * RADIX_LOG + 1,
  localparam int CW         = $clog2(NUM_DIGITS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_digit_valid,
  input  logic [radix_bits-1:0] i_digit,
  output logic                  o_busy,
  output logic [W-1:0]          o_result,
  output logic                  o_result_valid,
  output logic [CW-1:0]         o_digit_count
`ifdef OTB_DIGIT_CHECK_EN
  ,
  output logic                  o_digit_error
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [W-1:0]         r_q;
  logic [W-1:0]         r_qm;
  logic [W-1:0]         r_result;
  logic [CW-1:0]        r_digit_count;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_neg;
  logic                 w_pos;
  logic [RADIX_LOG-1:0] w_dlo;
  logic [RADIX_LOG-1:0] w_dm1;
  logic [W-1:0]         w_q_base;
  logic [W-1:0]         w_qm_base;
  logic [W-1:0]         w_q_next;
  logic [W-1:0]         w_qm_next;

  assign w_accept = (r_state == S_CONVERT) && i_digit_valid && !i_start;
  assign w_last   = w_accept && (r_digit_count == CW'(NUM_DIGITS - 1));

  // Low RADIX_LOG bits of d, r+d, d-1 and r-1+d reduce to d or d-1 modulo r.
  assign w_neg     = i_digit[radix_bits-1];
  assign w_dlo     = i_digit[RADIX_LOG-1:0];
  assign w_pos     = !w_neg && (|w_dlo);
  assign w_dm1     = w_dlo - RADIX_LOG'(1);
  assign w_q_base  = w_neg ? r_qm : r_q;
  assign w_qm_base = w_pos ? r_q  : r_qm;
  assign w_q_next  = (w_q_base  << RADIX_LOG) | W'(w_dlo);
  assign w_qm_next = (w_qm_base << RADIX_LOG) | W'(w_dm1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_CONVERT;
      end
      S_CONVERT: begin
        if (i_start)     w_state_next = S_CONVERT;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = i_start ? S_CONVERT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (r_state == S_CONVERT);
    o_result_valid = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q           <= '0;
      r_qm          <= '1;
      r_result      <= '0;
      r_digit_count <= '0;
    end else if (i_start) begin
      r_q           <= '0;
      r_qm          <= '1;
      r_digit_count <= '0;
    end else if (w_accept) begin
      r_q           <= w_q_next;
      r_qm          <= w_qm_next;
      r_digit_count <= r_digit_count + CW'(1);
      if (w_last) r_result <= w_q_next;
    end
  end

  assign o_result      = r_result;
  assign o_digit_count = r_digit_count;

`ifdef OTB_DIGIT_CHECK_EN
  logic r_digit_error;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      r_digit_error <= 1'b0;
    end else if (w_accept && w_neg && (w_dlo == '0)) begin
      r_digit_error <= 1'b1;
    end
  end

  assign o_digit_error = r_digit_error;
`else
  // No illegal-digit tracking in this build.
`endif

endmodule

// File: tb/tb_online_to_binary.sv
// Self-checking bench for online_to_binary (RADIX_LOG=2, NUM_DIGITS=4): random digit streams
// compared against an integer-sum reference model.
module tb_online_to_binary;

  localparam int RL = 2;
  localparam int N  = 4;
  localparam int W  = N * RL + 1;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          i_reset;
  logic          i_start;
  logic          i_digit_valid;
  logic [RL:0]   i_digit;
  logic          o_busy;
  logic [W-1:0]  o_result;
  logic          o_result_valid;
  logic [CW-1:0] o_digit_count;
`ifdef OTB_DIGIT_CHECK_EN
  logic          o_digit_error;
`endif

  int total = 0;
  int bad   = 0;

  online_to_binary #(.RADIX_LOG(RL), .NUM_DIGITS(N)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_digit_valid  (i_digit_valid),
    .i_digit        (i_digit),
    .o_busy         (o_busy),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_digit_count  (o_digit_count)
`ifdef OTB_DIGIT_CHECK_EN
    ,
    .o_digit_error  (o_digit_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_value(input int d [N]);
    int val;
    val = 0;
    for (int i = 0; i < N; i++) val = val * (1 << RL) + d[i];
    return W'(val);
  endfunction

  // Start an operand (random ignored digit on the start cycle), feed N digits with gaps, check each cycle.
  task automatic drive_operand(input int d [N], input int min_gap, input int max_gap,
                               input string tag, output logic [W-1:0] exp);
    int gaps;
    exp = model_value(d);
    i_start       = 1'b1;
    i_digit_valid = 1'($urandom_range(0, 1));
    i_digit       = 3'($urandom_range(0, 6));
    step();
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1 || o_digit_count !== '0) begin
      bad++;
      $display("FAIL %s start: busy=%0b count=%0d want busy=1 count=0", tag, o_busy, o_digit_count);
    end
    for (int i = 0; i < N; i++) begin
      gaps = int'($urandom_range(min_gap, max_gap));
      for (int g = 0; g < gaps; g++) begin
        i_digit_valid = 1'b0;
        i_digit       = 3'($urandom_range(0, 7));
        step();
        total++;
        if (o_busy !== 1'b1 || o_result_valid !== 1'b0 || o_digit_count !== CW'(i)) begin
          bad++;
          $display("FAIL %s gap: busy=%0b rv=%0b count=%0d want 1 0 %0d",
                   tag, o_busy, o_result_valid, o_digit_count, i);
        end
      end
      i_digit_valid = 1'b1;
      i_digit       = 3'(d[i]);
      step();
      total++;
      if (i < N - 1) begin
        if (o_result_valid !== 1'b0 || o_digit_count !== CW'(i + 1)) begin
          bad++;
          $display("FAIL %s digit%0d: rv=%0b count=%0d want 0 %0d",
                   tag, i, o_result_valid, o_digit_count, i + 1);
        end
      end else begin
        if (o_result_valid !== 1'b1 || o_result !== exp || o_busy !== 1'b0) begin
          bad++;
          $display("FAIL %s result: rv=%0b result=%h busy=%0b want 1 %h 0",
                   tag, o_result_valid, o_result, o_busy, exp);
        end
      end
    end
    i_digit_valid = 1'b0;
  endtask

  // After DONE: digits in DONE/IDLE are ignored, result held, pulse only one cycle.
  task automatic test_idle_after(input string tag, input logic [W-1:0] exp);
    for (int k = 0; k < 2; k++) begin
      i_digit_valid = 1'b1;
      i_digit       = 3'($urandom_range(0, 6));
      step();
      total++;
      if (o_result_valid !== 1'b0 || o_busy !== 1'b0 || o_digit_count !== CW'(N) || o_result !== exp) begin
        bad++;
        $display("FAIL %s idle%0d: rv=%0b busy=%0b count=%0d result=%h want 0 0 %0d %h",
                 tag, k, o_result_valid, o_busy, o_digit_count, o_result, N, exp);
      end
    end
    i_digit_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b1; i_digit_valid = 1'b1; i_digit = 3'd1;
    step();
    step();
    i_reset = 1'b0; i_start = 1'b0; i_digit_valid = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_result !== '0 || o_result_valid !== 1'b0 || o_digit_count !== '0) begin
      bad++;
      $display("FAIL reset: busy=%0b result=%h rv=%0b count=%0d want all zero",
               o_busy, o_result, o_result_valid, o_digit_count);
    end
`ifdef OTB_DIGIT_CHECK_EN
    total++;
    if (o_digit_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: digit_error=%0b want 0", o_digit_error);
    end
`endif
  endtask

  task automatic test_vectors();
    logic [W-1:0] exp;
    int d [N];
    d = '{1, -1, 0, 1};
    drive_operand(d, 0, 0, "vec49", exp);
    total++;
    if (o_result !== 9'h031) begin
      bad++;
      $display("FAIL vec49_const: result=%h want 031", o_result);
    end
    test_idle_after("vec49", exp);
    d = '{-3, -3, -3, -3};
    drive_operand(d, 1, 1, "vecm255", exp);
    test_idle_after("vecm255", exp);
    d = '{3, 3, 3, 3};
    drive_operand(d, 1, 1, "vec255", exp);
    test_idle_after("vec255", exp);
    d = '{0, 0, 0, -1};
    drive_operand(d, 0, 0, "vecm1", exp);
    test_idle_after("vecm1", exp);
  endtask

  task automatic test_abort();
    logic [W-1:0] exp;
    int d [N];
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_digit_valid = 1'b1; i_digit = 3'(2);
    step();
    i_digit = 3'(-2);
    step();
    i_digit_valid = 1'b0;
    total++;
    if (o_digit_count !== CW'(2) || o_result_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre: count=%0d rv=%0b want 2 0", o_digit_count, o_result_valid);
    end
    d = '{1, 0, 0, 0};
    drive_operand(d, 0, 0, "abort", exp);
    test_idle_after("abort", exp);
  endtask

  task automatic test_reset_mid();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_digit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_digit = 3'(1);
      step();
    end
    i_digit_valid = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_digit_valid = 1'b1; i_digit = 3'(1);
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (o_result_valid !== 1'b0 || o_result !== '0 || o_busy !== 1'b0 || o_digit_count !== '0) begin
        bad++;
        $display("FAIL reset_mid%0d: rv=%0b result=%h busy=%0b count=%0d want 0 0 0 0",
                 k, o_result_valid, o_result, o_busy, o_digit_count);
      end
    end
    i_digit_valid = 1'b0;
  endtask

  // Random operands; roughly half start the next operand in the DONE cycle.
  task automatic test_back_to_back();
    logic [W-1:0] exp;
    int d [N];
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 6)) - 3;
      drive_operand(d, 0, 2, "rand", exp);
      if ($urandom_range(0, 1) == 1) test_idle_after("rand", exp);
    end
    test_idle_after("rand_end", exp);
  endtask

`ifdef OTB_DIGIT_CHECK_EN
  task automatic test_digit_error();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_digit_valid = 1'b1; i_digit = 3'b100;
    step();
    i_digit = 3'(1);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (o_digit_error !== 1'b1) begin
        bad++;
        $display("FAIL digit_error%0d: got %0b want 1", k, o_digit_error);
      end
      step();
    end
    i_digit_valid = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    total++;
    if (o_digit_error !== 1'b0) begin
      bad++;
      $display("FAIL digit_error_clr: got %0b want 0", o_digit_error);
    end
  endtask
`endif

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_digit_valid = 1'b0; i_digit = '0;
    step();
    test_reset();
    test_vectors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef OTB_DIGIT_CHECK_EN
    test_digit_error();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/online_to_binary.md
ONLINE_TO_BINARY -- requirements
Module: online_to_binary

Interface
REQ-001 SHALL have parameter RADIX_LOG, default 2, log2 of the radix r (r = 2^RADIX_LOG).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, number of digits per operand, MSD first.
REQ-003 SHALL have derived localparams radix_bits = RADIX_LOG+1 (digit width) and W = NUM_DIGITS*RADIX_LOG+1 (result width).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a new operand; clears conversion state.
REQ-007 digit_valid  input  1  digit carries a valid signed digit this cycle.
REQ-008 digit  input  radix_bits  two's-complement signed digit, legal set [-(r-1), r-1] (radix_bits=3: 3'b111=-1, 3'b000=0, 3'b001=+1).
REQ-009 busy  output  1  high while in CONVERT.
REQ-010 result  output  W  two's-complement value of the completed operand.
REQ-011 result_valid  output  1  one-cycle pulse when result updates.
REQ-012 digit_count  output  $clog2(NUM_DIGITS+1)  digits accepted in current operand.
REQ-013 digit_error  output  1  sticky illegal-digit flag (present only per REQ-030).

Function
REQ-014 SHALL implement FSM states IDLE, CONVERT, DONE.
REQ-015 IDLE: start -> CONVERT; Q <= 0, QM <= all ones (-1), digit_count <= 0; digit_valid ignored.
REQ-016 Start-cycle digit SHALL be ignored; the first digit is accepted on the following cycles.
REQ-017 CONVERT, digit_valid=1, d>=0: Q <= {Q[W-1-RADIX_LOG:0], d[RADIX_LOG-1:0]}.
REQ-018 CONVERT, digit_valid=1, d<0: Q <= {QM[W-1-RADIX_LOG:0], (r+d)[RADIX_LOG-1:0]}.
REQ-019 CONVERT, digit_valid=1, d>0: QM <= {Q shifted, d-1}; d<=0: QM <= {QM shifted, r-1+d}; invariant QM = Q-1 holds after every step.
REQ-020 Each accepted digit SHALL increment digit_count; digit_valid=0 holds all state (gaps allowed).
REQ-021 On acceptance of digit NUM_DIGITS: next cycle result <= final Q, result_valid=1, state DONE.
REQ-022 Latency SHALL be exactly 1 cycle from last accepted digit to result_valid.
REQ-023 DONE lasts one cycle then -> IDLE unless start asserted, which -> CONVERT directly.
REQ-024 start in CONVERT SHALL abort the current operand and restart per REQ-015; no result_valid for the aborted operand.
REQ-025 result SHALL hold its value until the next result_valid pulse.
REQ-026 digit_valid in IDLE/DONE SHALL be ignored and not counted.
REQ-027 Result SHALL be exact: |value| <= r^NUM_DIGITS-1 always fits W bits; no overflow detection required.

Reset
REQ-028 reset SHALL force state IDLE, Q=0, QM=all ones, result=0, result_valid=0, busy=0, digit_count=0, digit_error=0.
REQ-029 reset SHALL take priority over start and digit_valid; asserted mid-operand, the operand is discarded, no result_valid.

Configuration
REQ-030 Macro OTB_DIGIT_CHECK_EN defined: accepted digit equal to -r (pattern 1 followed by zeros) SHALL set digit_error, cleared only by reset or start; digit still converted per REQ-018.
REQ-031 Macro OTB_DIGIT_CHECK_EN undefined: digit_error port and its logic SHALL be absent; behaviour otherwise identical.

Verification (RADIX_LOG=2, NUM_DIGITS=4, W=9)
REQ-032 start, then digits +1,-1,0,+1 consecutive -> one cycle after 4th digit result=9'h031 (49), result_valid one cycle.
REQ-033 start, digits -3,-3,-3,-3 with one-cycle gaps between each -> result=9'h101 (-255); all +3 -> 9'h0FF (255); 0,0,0,-1 -> 9'h1FF (-1).
REQ-034 start, 2 digits, start again, then +1,0,0,0 -> single result_valid, result=9'h040 (64).
REQ-035 reset asserted after 3rd digit, then 4th digit -> no result_valid, result=0, busy=0.
REQ-036 With OTB_DIGIT_CHECK_EN: digit 3'b100 accepted -> digit_error=1 next cycle, stays 1 until start; without macro port absent and build clean.
